// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
//   - opsel field positions
//   - ALU and compare operation codes
//   - top-level FSM state type and iterative-unit operation type
package alu_pkg;

    // opsel layout: [5] address calc, [4] compare, [3:0] operation code
    localparam int OPSEL_W      = 6;
    localparam int OPSEL_ADDR   = 5;
    localparam int OPSEL_CMP    = 4;
    localparam int OPSEL_CODE_W = 4;

    // ALU codes (opsel[5:4] == 2'b00)
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_MUL  = 4'd2;
    localparam logic [3:0] ALU_DIV  = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_REM  = 4'd7;
    localparam logic [3:0] ALU_MVHI = 4'd11;
    localparam logic [3:0] ALU_NAND = 4'd12;
    localparam logic [3:0] ALU_NOR  = 4'd13;
    localparam logic [3:0] ALU_XNOR = 4'd14;

    // Compare codes (opsel[4] == 1), all signed, result 0/1
    localparam logic [3:0] CMP_F    = 4'd0;
    localparam logic [3:0] CMP_EQ   = 4'd1;
    localparam logic [3:0] CMP_LT   = 4'd2;
    localparam logic [3:0] CMP_LTE  = 4'd3;
    localparam logic [3:0] CMP_EQZ  = 4'd5;
    localparam logic [3:0] CMP_LTZ  = 4'd6;
    localparam logic [3:0] CMP_LTEZ = 4'd7;
    localparam logic [3:0] CMP_T    = 4'd8;
    localparam logic [3:0] CMP_NE   = 4'd9;
    localparam logic [3:0] CMP_GTE  = 4'd10;
    localparam logic [3:0] CMP_GT   = 4'd11;
    localparam logic [3:0] CMP_NEZ  = 4'd13;
    localparam logic [3:0] CMP_GTEZ = 4'd14;
    localparam logic [3:0] CMP_GTZ  = 4'd15;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    typedef enum logic [1:0] {MD_MUL, MD_DIV, MD_REM} md_op_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative signed multiply / divide / remainder unit.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and begin (pulse, only while idle)
//   op         : MD_MUL, MD_DIV or MD_REM
//   a, b       : signed operands, sampled on start
//   done       : result valid this cycle (one-cycle pulse)
//   result     : sign-corrected product low bits / quotient / remainder
//   dz         : DIV/REM with b == 0; reported combinationally alongside start
// Works on magnitudes for WIDTH iterations and fixes the sign at the end.
// The final iteration's next-state values feed the result directly, so the
// result is available in the cycle of the last iteration, WIDTH cycles after
// start. A zero divisor skips iteration and answers in the start cycle.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic             busy_reg;
    md_op_t           op_reg;
    logic             neg_reg;
    logic [CW-1:0]    count_reg;
    // MUL: acc = partial product, opa = shifted multiplicand, opb = multiplier
    // DIV: acc = partial remainder, opa = dividend shifting into quotient, opb = divisor
    logic [WIDTH-1:0] acc_reg, opa_reg, opb_reg;
    logic [WIDTH-1:0] acc_next, opa_next, opb_next;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             zero_div;
    logic             last_iter;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        // The most negative value maps onto itself, which is its correct
        // unsigned magnitude.
        return x[WIDTH-1] ? -x : x;
    endfunction

    assign zero_div  = start && (op != MD_MUL) && (b == '0);
    assign last_iter = busy_reg && (count_reg == CW'(WIDTH - 1));
    assign done      = zero_div | last_iter;
    assign dz        = zero_div;

    // Restoring division step: bring down the next dividend bit and subtract
    // the divisor; a set borrow bit means the trial went negative.
    assign rem_shift = {acc_reg, opa_reg[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, opb_reg};

    always_comb begin
        acc_next = acc_reg;
        opa_next = opa_reg;
        opb_next = opb_reg;
        if (op_reg == MD_MUL) begin
            if (opb_reg[0]) begin
                acc_next = acc_reg + opa_reg;
            end
            opa_next = opa_reg << 1;
            opb_next = opb_reg >> 1;
        end else begin
            if (!rem_diff[WIDTH]) begin
                acc_next = rem_diff[WIDTH-1:0];
                opa_next = {opa_reg[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = rem_shift[WIDTH-1:0];
                opa_next = {opa_reg[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        if (zero_div) begin
            result = (op == MD_REM) ? a : '1;
        end else if (op_reg == MD_DIV) begin
            result = neg_reg ? -opa_next : opa_next;
        end else begin
            result = neg_reg ? -acc_next : acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg  <= 1'b0;
            op_reg    <= MD_MUL;
            neg_reg   <= 1'b0;
            count_reg <= '0;
            acc_reg   <= '0;
            opa_reg   <= '0;
            opb_reg   <= '0;
        end else if (start && !zero_div) begin
            busy_reg  <= 1'b1;
            op_reg    <= op;
            count_reg <= '0;
            acc_reg   <= '0;
            opa_reg   <= mag(a);
            opb_reg   <= mag(b);
            // Remainder follows the dividend's sign; product and quotient
            // are negative when the operand signs differ.
            neg_reg   <= (op == MD_REM) ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (busy_reg) begin
            acc_reg   <= acc_next;
            opa_reg   <= opa_next;
            opb_reg   <= opb_next;
            count_reg <= count_reg + CW'(1);
            if (last_iter) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_muldiv_pipe.sv
// Execute-stage ALU with valid/ready handshakes on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operation handshake (transfer = in_valid & in_ready)
//   opsel               : [5] address calc, [4] compare, [3:0] operation code
//   A, B                : signed operands, sampled on transfer
//   out_valid/out_ready : result handshake (transfer = out_valid & out_ready)
//   out                 : result register
//   div_zero            : the result is a DIV/REM with a zero divisor
// Single-cycle operations land in the output register at the end of the
// transfer cycle. MUL/DIV/REM run in alu_iter_muldiv while the FSM blocks new
// input. One result is held until the consumer takes it; a new op may be
// accepted in the same cycle the old result drains.
module alu_muldiv_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_SHIFT = 2,
    parameter bit MULDIV_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPSEL_W-1:0] opsel,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out,
    output logic               div_zero
);

    state_t                  state_reg;
    logic [WIDTH-1:0]        out_reg;
    logic                    out_valid_reg;
    logic                    div_zero_reg;

    logic [OPSEL_CODE_W-1:0] code;
    logic                    is_cmp;
    logic                    is_addr;
    logic                    is_md_code;
    logic                    accept;
    logic                    start_md;
    md_op_t                  md_op;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic                    a_zero, a_neg;
    logic                    cmp_bit;
    logic [WIDTH-1:0]        addr_res;
    logic [WIDTH-1:0]        mvhi_res;
    logic [WIDTH-1:0]        alu_res;
    logic [WIDTH-1:0]        single_res;

    logic                    md_done;
    logic [WIDTH-1:0]        md_result;
    logic                    md_dz;

    // ---------------- decode ----------------
    // Compare outranks address calc, which outranks the plain ALU code.
    assign code       = opsel[OPSEL_CODE_W-1:0];
    assign is_cmp     = opsel[OPSEL_CMP];
    assign is_addr    = opsel[OPSEL_ADDR] & ~opsel[OPSEL_CMP];
    assign is_md_code = (code == ALU_MUL) || (code == ALU_DIV) || (code == ALU_REM);

    always_comb begin
        md_op = MD_REM;
        if (code == ALU_MUL) begin
            md_op = MD_MUL;
        end else if (code == ALU_DIV) begin
            md_op = MD_DIV;
        end
    end

    // ---------------- handshake ----------------
    // Reset also closes the input so nothing is taken while rst_n is low.
    assign in_ready = rst_n && (state_reg == IDLE) && (!out_valid_reg || out_ready);
    assign accept   = in_valid & in_ready;
    assign start_md = accept & ~is_cmp & ~opsel[OPSEL_ADDR] & is_md_code & MULDIV_EN;

    // ---------------- single-cycle datapath ----------------
    assign a_s    = A;
    assign b_s    = B;
    assign a_zero = (A == '0);
    assign a_neg  = A[WIDTH-1];

    always_comb begin
        cmp_bit = 1'b0;
        case (code)
            CMP_F:    cmp_bit = 1'b0;
            CMP_EQ:   cmp_bit = (a_s == b_s);
            CMP_LT:   cmp_bit = (a_s < b_s);
            CMP_LTE:  cmp_bit = (a_s <= b_s);
            CMP_EQZ:  cmp_bit = a_zero;
            CMP_LTZ:  cmp_bit = a_neg;
            CMP_LTEZ: cmp_bit = a_neg | a_zero;
            CMP_T:    cmp_bit = 1'b1;
            CMP_NE:   cmp_bit = (a_s != b_s);
            CMP_GTE:  cmp_bit = (a_s >= b_s);
            CMP_GT:   cmp_bit = (a_s > b_s);
            CMP_NEZ:  cmp_bit = ~a_zero;
            CMP_GTEZ: cmp_bit = ~a_neg;
            CMP_GTZ:  cmp_bit = ~a_neg & ~a_zero;
            default:  cmp_bit = 1'b0;
        endcase
    end

    assign addr_res = A + (B << ADDR_SHIFT);

    // Move-high places B's low halfword at the top of the result. On datapaths
    // narrower than a halfword B simply passes through.
    generate
        if (WIDTH > 16) begin : g_mvhi_wide
            assign mvhi_res = {B[15:0], {(WIDTH-16){1'b0}}};
        end else if (WIDTH == 16) begin : g_mvhi_half
            assign mvhi_res = B[15:0];
        end else begin : g_mvhi_narrow
            assign mvhi_res = B;
        end
    endgenerate

    always_comb begin
        alu_res = '0;
        case (code)
            ALU_ADD:  alu_res = A + B;
            ALU_SUB:  alu_res = A - B;
            ALU_AND:  alu_res = A & B;
            ALU_OR:   alu_res = A | B;
            ALU_XOR:  alu_res = A ^ B;
            ALU_MVHI: alu_res = mvhi_res;
            ALU_NAND: alu_res = ~(A & B);
            ALU_NOR:  alu_res = ~(A | B);
            ALU_XNOR: alu_res = ~(A ^ B);
            // MUL/DIV/REM only reach here when the iterative unit is disabled.
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        if (is_cmp) begin
            single_res = {{(WIDTH-1){1'b0}}, cmp_bit};
        end else if (is_addr) begin
            single_res = addr_res;
        end else begin
            single_res = alu_res;
        end
    end

    // ---------------- iterative unit ----------------
    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_md),
        .op     (md_op),
        .a      (A),
        .b      (B),
        .done   (md_done),
        .result (md_result),
        .dz     (md_dz)
    );

    // ---------------- FSM and output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            div_zero_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (start_md && !md_done) begin
                            // Any held result drains in this same cycle.
                            state_reg     <= (md_op == MD_MUL) ? MUL : DIV;
                            out_valid_reg <= 1'b0;
                        end else begin
                            // A zero-divisor DIV/REM answers like a single-cycle op.
                            out_reg       <= start_md ? md_result : single_res;
                            div_zero_reg  <= start_md & md_dz;
                            out_valid_reg <= 1'b1;
                        end
                    end else if (out_valid_reg && out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                MUL, DIV: begin
                    if (md_done) begin
                        out_reg       <= md_result;
                        div_zero_reg  <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign div_zero  = div_zero_reg;

endmodule
